// File: rtl/scan_reg_seq_if.sv
// Scan register bus: controller-side handshake, scan data and status.
interface scan_reg_seq_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             ce;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             sout;
    logic             sen;
    logic             cap;
    logic             upd;
    logic             start;
    logic [CW-1:0]    len;
    logic             auto_upd;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] upd_q;
    logic             busy;
    logic             done;

    modport master (
        output ce, d, sin, sen, cap, upd, start, len, auto_upd,
        input  sout, q, upd_q, busy, done
    );

    modport slave (
        input  ce, d, sin, sen, cap, upd, start, len, auto_upd,
        output sout, q, upd_q, busy, done
    );
endinterface

// File: rtl/scan_reg_seq.sv
// Parametrised scan register with shadow register and capture/shift/update sequencer.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | manual sen/cap/upd honoured; start launches a sequence
// S_CAPT  | q <= d
// S_SHIFT | one shift per enabled cycle, cnt counts down to 1
// S_UPD   | upd_q <= q
// S_DONE  | one-cycle completion marker, then back to IDLE
module scan_reg_seq #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 0,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           clr_n,
    scan_reg_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_SHIFT,
        S_UPD,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             aupd_q, aupd_d;
    logic [WIDTH-1:0] shifted;

    // One-bit shift of the scan register in the configured direction.
    always_comb begin
        shifted = shreg_q;
        if (MSB_FIRST != 0) begin
            shifted = {shreg_q[WIDTH-2:0], bus.sin};
        end else begin
            shifted = {bus.sin, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state and datapath updates; ce low leaves everything at its held value.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        aupd_d   = aupd_q;
        if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_d   = (bus.len > WIDTH_C) ? WIDTH_C : bus.len;
                        aupd_d  = bus.auto_upd;
                        state_d = S_CAPT;
                    end else begin
                        if (bus.sen) begin
                            shreg_d = shifted;
                        end else if (bus.cap) begin
                            shreg_d = bus.d;
                        end
                        // Update sees the pre-edge contents, so it can pair with a shift or capture.
                        if (bus.upd) begin
                            shadow_d = shreg_q;
                        end
                    end
                end
                S_CAPT: begin
                    shreg_d = bus.d;
                    if (cnt_q == '0) begin
                        state_d = aupd_q ? S_UPD : S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = aupd_q ? S_UPD : S_DONE;
                    end
                end
                S_UPD: begin
                    shadow_d = shreg_q;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low clear that overrides ce.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            aupd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            aupd_q   <= aupd_d;
        end
    end

    assign bus.q     = shreg_q;
    assign bus.upd_q = shadow_q;
    assign bus.sout  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_DONE);
endmodule

// File: tb/tb_scan_reg_seq.sv
// Self-checking bench for scan_reg_seq: 8-bit LSB-first, 8-bit MSB-first and 32-bit instances.
module tb_scan_reg_seq;
    logic clk = 1'b0;
    logic clr_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    scan_reg_seq_if #(.WIDTH(8))  if8  ();
    scan_reg_seq_if #(.WIDTH(8))  if8m ();
    scan_reg_seq_if #(.WIDTH(32)) if32 ();

    scan_reg_seq #(.WIDTH(8),  .MSB_FIRST(0)) dut8  (.clk(clk), .clr_n(clr_n), .bus(if8.slave));
    scan_reg_seq #(.WIDTH(8),  .MSB_FIRST(1)) dut8m (.clk(clk), .clr_n(clr_n), .bus(if8m.slave));
    scan_reg_seq #(.WIDTH(32), .MSB_FIRST(0)) dut32 (.clk(clk), .clr_n(clr_n), .bus(if32.slave));

    logic        exp_sout_q[$];
    logic [31:0] shadow32_exp;
    logic [7:0]  shadow8m_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if8.ce  = 1'b1; if8.d  = '0; if8.sin  = 1'b0; if8.sen  = 1'b0; if8.cap  = 1'b0;
        if8.upd = 1'b0; if8.start = 1'b0; if8.len = '0; if8.auto_upd = 1'b0;
        if8m.ce  = 1'b1; if8m.d  = '0; if8m.sin  = 1'b0; if8m.sen  = 1'b0; if8m.cap  = 1'b0;
        if8m.upd = 1'b0; if8m.start = 1'b0; if8m.len = '0; if8m.auto_upd = 1'b0;
        if32.ce  = 1'b1; if32.d  = '0; if32.sin  = 1'b0; if32.sen  = 1'b0; if32.cap  = 1'b0;
        if32.upd = 1'b0; if32.start = 1'b0; if32.len = '0; if32.auto_upd = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        clr_n = 1'b0;
        tick();
        tick();
        checks++; if (if8.q !== 8'h00) begin errors++; $display("FAIL rst_q got %h want 00", if8.q); end
        checks++; if (if8.upd_q !== 8'h00) begin errors++; $display("FAIL rst_upd_q got %h want 00", if8.upd_q); end
        checks++; if ({if8.busy, if8.done, if8.sout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {if8.busy, if8.done, if8.sout}); end
        checks++; if (if32.busy !== 1'b0) begin errors++; $display("FAIL rst_busy32 got %b want 0", if32.busy); end
        clr_n = 1'b1;
        // make state nonzero: capture+update on dut8, start a sequence on dut32
        if8.d = 8'h5A; if8.cap = 1'b1;
        if32.d = 32'h0000_00FF; if32.len = 6'd10; if32.start = 1'b1;
        tick();
        if8.cap = 1'b0; if8.upd = 1'b1; if32.start = 1'b0;
        tick();
        if8.upd = 1'b0;
        checks++; if (if8.upd_q !== 8'h5A) begin errors++; $display("FAIL pre_rst_upd_q got %h want 5a", if8.upd_q); end
        checks++; if (if32.busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy32 got %b want 1", if32.busy); end
        if8.ce = 1'b0; if8m.ce = 1'b0; if32.ce = 1'b0;
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        checks++; if (if8.q !== 8'h00 || if8.upd_q !== 8'h00) begin errors++; $display("FAIL rst_ce0_regs got q=%h upd_q=%h want 00/00", if8.q, if8.upd_q); end
        checks++; if (if32.busy !== 1'b0 || if32.done !== 1'b0 || if32.q !== 32'h0) begin errors++; $display("FAIL rst_ce0_fsm got busy=%b done=%b q=%h want 0/0/0", if32.busy, if32.done, if32.q); end
        idle_all();
        shadow32_exp = '0;
        shadow8m_exp = '0;
    endtask

    task automatic test_manual_scan();
        logic [7:0] m;
        logic       exp;
        m = 8'hA5;
        if8.d = 8'hA5; if8.cap = 1'b1;
        tick();
        if8.cap = 1'b0;
        checks++; if (if8.q !== m) begin errors++; $display("FAIL man_cap got %h want %h", if8.q, m); end
        if8.sin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_sout_q.push_back(m[0]);
            exp = exp_sout_q.pop_front();
            checks++; if (if8.sout !== exp) begin errors++; $display("FAIL man_sout[%0d] got %b want %b", i, if8.sout, exp); end
            if8.sen = 1'b1;
            tick();
            m = {1'b1, m[7:1]};
        end
        if8.sen = 1'b0;
        checks++; if (if8.q !== m) begin errors++; $display("FAIL man_shift_q got %h want %h", if8.q, m); end
        if8.upd = 1'b1;
        tick();
        if8.upd = 1'b0;
        checks++; if (if8.upd_q !== m) begin errors++; $display("FAIL man_upd got %h want %h", if8.upd_q, m); end
        // update alongside a shift takes the pre-shift contents
        if8.sin = 1'b0; if8.sen = 1'b1; if8.upd = 1'b1;
        tick();
        if8.sen = 1'b0; if8.upd = 1'b0;
        checks++; if (if8.upd_q !== m || if8.q !== {1'b0, m[7:1]}) begin errors++; $display("FAIL man_upd_shift got upd_q=%h q=%h want %h/%h", if8.upd_q, if8.q, m, {1'b0, m[7:1]}); end
    endtask

    // Runs one auto sequence on dut32, scoreboarding sout after every enabled edge from capture to last shift.
    task automatic run_seq32(input logic [31:0] dv, input int lenv, input bit au, input bit sinv,
                             input int gap_a, input int gap_n, output logic [31:0] q_exp,
                             output int idle_e, output int done_e, output int done_cnt);
        int          n, e, a, gaps;
        logic [31:0] m;
        logic        cur, exp;
        n = (lenv > 32) ? 32 : lenv;
        m = dv;
        exp_sout_q.delete();
        exp_sout_q.push_back(m[0]);
        for (int i = 0; i < n; i++) begin
            m = {sinv, m[31:1]};
            exp_sout_q.push_back(m[0]);
        end
        q_exp = m;
        if32.d = dv; if32.sin = sinv; if32.len = 6'(lenv); if32.auto_upd = au;
        if32.ce = 1'b1; if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        checks++; if (if32.busy !== 1'b1) begin errors++; $display("FAIL seq_start_busy got %b want 1", if32.busy); end
        e = 0; a = 0; gaps = 0; done_cnt = 0; done_e = -1;
        while (if32.busy === 1'b1 && e < 200) begin
            cur = if32.ce;
            tick();
            e++;
            if (cur) a++;
            if (cur && a <= n + 1) begin
                exp = exp_sout_q.pop_front();
                checks++; if (if32.sout !== exp) begin errors++; $display("FAIL seq_sout edge %0d got %b want %b", e, if32.sout, exp); end
            end
            if (if32.done === 1'b1) begin
                done_cnt++;
                done_e = e;
            end
            if (a == gap_a && gaps < gap_n) begin
                if32.ce = 1'b0;
                gaps++;
            end else begin
                if32.ce = 1'b1;
            end
        end
        if32.ce = 1'b1;
        idle_e = e;
        checks++; if (if32.busy !== 1'b0 || exp_sout_q.size() != 0) begin errors++; $display("FAIL seq_end got busy=%b pending=%0d want 0/0", if32.busy, exp_sout_q.size()); end
    endtask

    task automatic test_auto();
        logic [31:0] qe;
        int idle_e, done_e, done_cnt;
        run_seq32(32'h1234_5678, 32, 1'b1, 1'b0, -1, 0, qe, idle_e, done_e, done_cnt);
        shadow32_exp = qe;
        checks++; if (if32.q !== qe) begin errors++; $display("FAIL auto_q got %h want %h", if32.q, qe); end
        checks++; if (if32.upd_q !== shadow32_exp) begin errors++; $display("FAIL auto_upd_q got %h want %h", if32.upd_q, shadow32_exp); end
        checks++; if (idle_e != 35) begin errors++; $display("FAIL auto_busy_len got %0d want 35", idle_e); end
        checks++; if (done_cnt != 1 || done_e != 34) begin errors++; $display("FAIL auto_done got cnt=%0d edge=%0d want 1/34", done_cnt, done_e); end
    endtask

    task automatic run_seq8m(input logic [7:0] dv, input int lenv, input bit au,
                             output int done_e, output int idle_e);
        int e;
        if8m.d = dv; if8m.sin = 1'b1; if8m.len = 4'(lenv); if8m.auto_upd = au; if8m.start = 1'b1;
        tick();
        if8m.start = 1'b0;
        e = 0; done_e = -1;
        while (if8m.busy === 1'b1 && e < 50) begin
            tick();
            e++;
            if (if8m.done === 1'b1) done_e = e;
        end
        idle_e = e;
    endtask

    task automatic test_msb_first();
        logic [7:0] m;
        int done_e, idle_e;
        m = 8'h81;
        for (int i = 0; i < 3; i++) m = {m[6:0], 1'b1};
        run_seq8m(8'h81, 3, 1'b0, done_e, idle_e);
        checks++; if (if8m.q !== m) begin errors++; $display("FAIL msb_q got %h want %h", if8m.q, m); end
        checks++; if (if8m.upd_q !== shadow8m_exp) begin errors++; $display("FAIL msb_upd_q got %h want %h", if8m.upd_q, shadow8m_exp); end
        checks++; if (done_e != 4 || idle_e != 5) begin errors++; $display("FAIL msb_timing_noupd got done=%0d idle=%0d want 4/5", done_e, idle_e); end
        tick();
        run_seq8m(8'h81, 3, 1'b1, done_e, idle_e);
        shadow8m_exp = m;
        checks++; if (if8m.upd_q !== shadow8m_exp) begin errors++; $display("FAIL msb_upd_q_au got %h want %h", if8m.upd_q, shadow8m_exp); end
        checks++; if (done_e != 5 || idle_e != 6) begin errors++; $display("FAIL msb_timing_upd got done=%0d idle=%0d want 5/6", done_e, idle_e); end
        checks++; if (if8m.sout !== m[7]) begin errors++; $display("FAIL msb_sout got %b want %b", if8m.sout, m[7]); end
    endtask

    task automatic test_boundaries();
        logic [31:0] qe;
        int idle_e, done_e, done_cnt;
        run_seq32(32'hCAFE_F00D, 0, 1'b1, 1'b0, -1, 0, qe, idle_e, done_e, done_cnt);
        shadow32_exp = qe;
        checks++; if (if32.upd_q !== 32'hCAFE_F00D || if32.q !== 32'hCAFE_F00D) begin errors++; $display("FAIL len0 got q=%h upd_q=%h want cafef00d", if32.q, if32.upd_q); end
        checks++; if (idle_e != 3 || done_e != 2) begin errors++; $display("FAIL len0_timing got idle=%0d done=%0d want 3/2", idle_e, done_e); end
        tick();
        run_seq32(32'hA5A5_A5A5, 40, 1'b0, 1'b1, -1, 0, qe, idle_e, done_e, done_cnt);
        checks++; if (if32.q !== qe || if32.upd_q !== shadow32_exp) begin errors++; $display("FAIL len40_regs got q=%h upd_q=%h want %h/%h", if32.q, if32.upd_q, qe, shadow32_exp); end
        checks++; if (idle_e != 34 || done_e != 33) begin errors++; $display("FAIL len40_clamp got idle=%0d done=%0d want 34/33", idle_e, done_e); end
    endtask

    task automatic test_ce_gap();
        logic [31:0] qe;
        int idle_e, done_e, done_cnt;
        run_seq32(32'h0F0F_1234, 20, 1'b1, 1'b1, 6, 5, qe, idle_e, done_e, done_cnt);
        shadow32_exp = qe;
        checks++; if (if32.q !== qe || if32.upd_q !== qe) begin errors++; $display("FAIL gap_regs got q=%h upd_q=%h want %h", if32.q, if32.upd_q, qe); end
        checks++; if (idle_e != 28 || done_cnt != 1) begin errors++; $display("FAIL gap_timing got idle=%0d done_cnt=%0d want 28/1", idle_e, done_cnt); end
    endtask

    task automatic test_abort();
        int seen_done;
        if32.d = 32'hDEAD_BEEF; if32.len = 6'd32; if32.auto_upd = 1'b1; if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (if32.busy !== 1'b1 || if32.upd_q !== shadow32_exp) begin errors++; $display("FAIL abort_pre got busy=%b upd_q=%h want 1/%h", if32.busy, if32.upd_q, shadow32_exp); end
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        shadow32_exp = '0;
        checks++; if (if32.busy !== 1'b0 || if32.done !== 1'b0 || if32.q !== 32'h0 || if32.upd_q !== shadow32_exp) begin
            errors++; $display("FAIL abort_state got busy=%b done=%b q=%h upd_q=%h want 0/0/0/0", if32.busy, if32.done, if32.q, if32.upd_q);
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if32.done === 1'b1 || if32.busy === 1'b1) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen_done); end
    endtask

    initial begin
        clr_n = 1'b0;
        idle_all();
        test_reset();
        test_manual_scan();
        test_auto();
        tick();
        test_msb_first();
        test_boundaries();
        tick();
        test_ce_gap();
        tick();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
